// File: rtl/pattern_scan_controller_pkg.sv
// Shared definitions for the pattern scan controller: state encoding,
// requester indices and default geometry.
package pattern_scan_controller_pkg;

  localparam int DEF_WORD_W = 8;
  localparam int DEF_CNT_W  = 4;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_REPORT = 2'd3
  } state_e;

endpackage

// File: rtl/pattern_scan_controller_rr_arbiter2.sv
// Two-input round-robin arbiter. A lone request wins outright; on a tie the
// requester that did not win last time is chosen. The pointer only moves when
// the caller actually captures a word.
module rr_arbiter2
  import pattern_scan_controller_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic [1:0] gnt_o,
  output logic       idx_o
);

  logic last_q;

  // Pick the winner from the request pair and the last-winner pointer.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    idx_o = REQ0;
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   idx_o = REQ0;
      2'b10:   idx_o = REQ1;
      2'b11:   idx_o = ~last_q;
      default: idx_o = REQ0;
    endcase
    if (req_i != 2'b00) begin
      gnt_o = (idx_o == REQ1) ? 2'b10 : 2'b01;
    end
  end

  // Remember the winner; after reset requester 0 takes the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= REQ1;
    end else if (update_i && (req_i != 2'b00)) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      last_q <= idx_o;
    end
  end

endmodule

// File: rtl/pattern_scan_controller.sv
// Shares one serial Mealy detector between two word requesters: captures the
// winning word, clears the detector, streams the word MSB-first and reports
// the saturating count of detector match pulses seen during the stream.
module pattern_scan_controller
  import pattern_scan_controller_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              i_Clk,
  input  logic              Reset,
  input  logic [1:0]        i_Req,
  input  logic [WORD_W-1:0] i_Word0,
  input  logic [WORD_W-1:0] i_Word1,
  input  logic              i_X,
  output logic [1:0]        o_Grant,
  output logic              o_DetReset,
  output logic              o_Sequence,
  output logic              o_Busy,
  output logic              o_Done,
  output logic              o_DoneId,
  output logic [CNT_W-1:0]  o_MatchCount
);

  localparam int IDX_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e             state_q;
  logic [WORD_W-1:0]  shreg_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               owner_q;
  logic [1:0]         grant_q;
  logic               det_reset_q;
  logic               busy_q;
  logic               done_q;
  logic               done_id_q;
  logic [CNT_W-1:0]   match_q;

  logic [1:0]         arb_gnt;
  logic               arb_idx;
  logic               arb_update;

  assign arb_update = (state_q == ST_IDLE);

  rr_arbiter2 u_arb (
    .clk_i    (i_Clk),
    .rst_i    (Reset),
    .req_i    (i_Req),
    .update_i (arb_update),
    .gnt_o    (arb_gnt),
    .idx_o    (arb_idx)
  );

  // Saturating match count including the pulse for the bit on the wire now.
  always_comb begin
    cnt_d = cnt_q;
    if (i_X && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Scan FSM: capture, clear detector, serialize, report; pulses default low.
  always_ff @(posedge i_Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      owner_q     <= REQ0;
      grant_q     <= 2'b00;
      det_reset_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      done_id_q   <= 1'b0;
      match_q     <= '0;
    end else begin
      grant_q     <= 2'b00;
      det_reset_q <= 1'b0;
      done_q      <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (i_Req != 2'b00) begin
            shreg_q     <= (arb_idx == REQ1) ? i_Word1 : i_Word0;
            owner_q     <= arb_idx;
            grant_q     <= arb_gnt;
            det_reset_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          cnt_q   <= '0;
          idx_q   <= '0;
          state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          shreg_q <= {shreg_q[WORD_W-2:0], 1'b0};
          idx_q   <= idx_q + 1'b1;
          cnt_q   <= cnt_d;
          if (idx_q == LAST_IDX) begin
            done_q    <= 1'b1;
            done_id_q <= owner_q;
            match_q   <= cnt_d;
            state_q   <= ST_REPORT;
          end
        end
        ST_REPORT: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_Grant      = grant_q;
  assign o_DetReset   = det_reset_q;
  assign o_Sequence   = (state_q == ST_SHIFT) ? shreg_q[WORD_W-1] : 1'b0;
  assign o_Busy       = busy_q;
  assign o_Done       = done_q;
  assign o_DoneId     = done_id_q;
  assign o_MatchCount = match_q;

endmodule

// File: tb/tb_pattern_scan_controller.sv
// Directed bench for pattern_scan_controller: a default instance (CNT_W=4)
// and a narrow-counter instance (CNT_W=2) driven by the same stimulus.
`timescale 1ns/100ps
module tb_pattern_scan_controller;

  logic       clk;
  logic       rst;
  logic [1:0] i_req;
  logic [7:0] i_word0;
  logic [7:0] i_word1;
  logic       i_x;

  logic [1:0] grant, s_grant;
  logic       det_reset, s_det_reset;
  logic       sequence_o, s_sequence;
  logic       busy, s_busy;
  logic       done, s_done;
  logic       done_id, s_done_id;
  logic [3:0] match_cnt;
  logic [1:0] s_match_cnt;

  int checks = 0;
  int errors = 0;

  pattern_scan_controller #(.WORD_W(8), .CNT_W(4)) dut (
    .i_Clk        (clk),
    .Reset        (rst),
    .i_Req        (i_req),
    .i_Word0      (i_word0),
    .i_Word1      (i_word1),
    .i_X          (i_x),
    .o_Grant      (grant),
    .o_DetReset   (det_reset),
    .o_Sequence   (sequence_o),
    .o_Busy       (busy),
    .o_Done       (done),
    .o_DoneId     (done_id),
    .o_MatchCount (match_cnt)
  );

  pattern_scan_controller #(.WORD_W(8), .CNT_W(2)) dut_sat (
    .i_Clk        (clk),
    .Reset        (rst),
    .i_Req        (i_req),
    .i_Word0      (i_word0),
    .i_Word1      (i_word1),
    .i_X          (i_x),
    .o_Grant      (s_grant),
    .o_DetReset   (s_det_reset),
    .o_Sequence   (s_sequence),
    .o_Busy       (s_busy),
    .o_Done       (s_done),
    .o_DoneId     (s_done_id),
    .o_MatchCount (s_match_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete word from the IDLE capture edge to the following IDLE cycle.
  // i_X is held high outside SHIFT so any out-of-window counting shows up.
  task automatic run_word(input string tag, input logic [1:0] req_in,
                          input logic [7:0] w0, input logic [7:0] w1,
                          input logic [1:0] hold_req, input logic [7:0] xmask,
                          input logic exp_owner, input logic [7:0] exp_bits,
                          input logic [3:0] exp_cnt, input logic [1:0] exp_sat);
    logic [1:0] exp_gnt;
    exp_gnt = exp_owner ? 2'b10 : 2'b01;
    i_req = req_in; i_word0 = w0; i_word1 = w1; i_x = 1'b1;
    check({tag, ".idle_busy"}, busy, 0);
    tick();
    check({tag, ".clr_grant"}, grant, exp_gnt);
    check({tag, ".clr_detrst"}, det_reset, 1);
    check({tag, ".clr_busy"}, busy, 1);
    check({tag, ".clr_seq"}, sequence_o, 0);
    check({tag, ".clr_done"}, done, 0);
    check({tag, ".clr_sgrant"}, s_grant, exp_gnt);
    i_req = hold_req;
    for (int k = 0; k < 8; k++) begin
      tick();
      check({tag, $sformatf(".seq%0d", k)}, sequence_o, exp_bits[7-k]);
      check({tag, $sformatf(".sseq%0d", k)}, s_sequence, exp_bits[7-k]);
      check({tag, $sformatf(".sh_grant%0d", k)}, grant, 0);
      check({tag, $sformatf(".sh_detrst%0d", k)}, det_reset, 0);
      check({tag, $sformatf(".sh_done%0d", k)}, done, 0);
      i_x = xmask[k];
    end
    tick();
    i_x = 1'b1;
    check({tag, ".rep_done"}, done, 1);
    check({tag, ".rep_id"}, done_id, exp_owner);
    check({tag, ".rep_cnt"}, match_cnt, exp_cnt);
    check({tag, ".rep_sdone"}, s_done, 1);
    check({tag, ".rep_scnt"}, s_match_cnt, exp_sat);
    check({tag, ".rep_busy"}, busy, 1);
    check({tag, ".rep_seq"}, sequence_o, 0);
    tick();
    check({tag, ".idle_done"}, done, 0);
    check({tag, ".idle_busy2"}, busy, 0);
    check({tag, ".idle_cnt_hold"}, match_cnt, exp_cnt);
    check({tag, ".idle_id_hold"}, done_id, exp_owner);
    check({tag, ".idle_grant"}, grant, 0);
  endtask

  initial begin
    rst = 1'b1; i_req = 2'b00; i_word0 = 8'h00; i_word1 = 8'h00; i_x = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.grant", grant, 0);
    check("rst.detrst", det_reset, 0);
    check("rst.seq", sequence_o, 0);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.id", done_id, 0);
    check("rst.cnt", match_cnt, 0);
    rst = 1'b0;
    tick();
    check("post_rst.busy", busy, 0);

    // Single request: B4 with matches on SHIFT cycles 3 and 6.
    run_word("single", 2'b01, 8'hB4, 8'h00, 2'b00, 8'h24, 1'b0, 8'hB4, 4'd2, 2'd2);

    // Second word straight after: detector cleared again, counter restarts.
    run_word("second", 2'b10, 8'h00, 8'h5A, 2'b00, 8'h00, 1'b1, 8'h5A, 4'd0, 2'd0);

    // Saturation: match on every bit; narrow counter stops at 3.
    run_word("sat", 2'b01, 8'hFF, 8'h00, 2'b00, 8'hFF, 1'b0, 8'hFF, 4'd8, 2'd3);

    // Late request from requester 1 raised while requester 0's word runs.
    run_word("late_a", 2'b01, 8'h3C, 8'hC3, 2'b10, 8'h0F, 1'b0, 8'h3C, 4'd4, 2'd3);
    run_word("late_b", 2'b10, 8'h3C, 8'hC3, 2'b00, 8'h81, 1'b1, 8'hC3, 4'd2, 2'd2);

    // Reset mid-SHIFT after a requester-0 win (pointer now favours 1).
    run_word("pre_rst", 2'b01, 8'h11, 8'h22, 2'b00, 8'h00, 1'b0, 8'h11, 4'd0, 2'd0);
    i_req = 2'b01; i_word0 = 8'hAA; i_x = 1'b1;
    tick();
    check("midrst.clr_grant", grant, 2'b01);
    i_req = 2'b00;
    repeat (5) tick();
    check("midrst.bit4_busy", busy, 1);
    check("midrst.bit4_seq", sequence_o, 1);
    #2 rst = 1'b1;
    #0.5;
    check("midrst.grant", grant, 0);
    check("midrst.detrst", det_reset, 0);
    check("midrst.seq", sequence_o, 0);
    check("midrst.busy", busy, 0);
    check("midrst.done", done, 0);
    check("midrst.id", done_id, 0);
    check("midrst.cnt", match_cnt, 0);
    check("midrst.scnt", s_match_cnt, 0);
    #0.5 rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      check($sformatf("midrst.no_done%0d", c), done, 0);
    end

    // Tie held continuously: grants alternate 0,1,0,1 from reset.
    run_word("tie0", 2'b11, 8'h81, 8'h7E, 2'b11, 8'h01, 1'b0, 8'h81, 4'd1, 2'd1);
    run_word("tie1", 2'b11, 8'h81, 8'h7E, 2'b11, 8'h03, 1'b1, 8'h7E, 4'd2, 2'd2);
    run_word("tie2", 2'b11, 8'h81, 8'h7E, 2'b11, 8'h07, 1'b0, 8'h81, 4'd3, 2'd3);
    run_word("tie3", 2'b11, 8'h81, 8'h7E, 2'b00, 8'h0F, 1'b1, 8'h7E, 4'd4, 2'd3);
    i_req = 2'b00;
    tick();
    check("end.busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_scan_controller.md
# pattern_scan_controller

Scheduler that shares one serial Mealy sequence detector between two parallel-word requesters. It accepts a WORD_W-bit word from the winning requester and clears the detector. It then streams the word MSB-first onto the detector's serial input and counts the detector's match pulses. It reports the match count per word. It sits between the word-producing logic and the detector instance, driving the detector's Sequence and Reset pins and consuming its X output.

## Interface
Parameters:
- WORD_W, 8, bits per word streamed to the detector (≥2)
- CNT_W, 4, match counter width (saturating)

Ports:
- i_Clk  in  1  single clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-high reset
- i_Req  in  2  per-requester request; held with its word until granted
- i_Word0  in  WORD_W  requester 0 word
- i_Word1  in  WORD_W  requester 1 word
- i_X  in  1  detector match output (Mealy: combinational on o_Sequence and detector state)
- o_Grant  out  2  one-hot, one-cycle acknowledge of captured word
- o_DetReset  out  1  active-high detector clear, one cycle per word
- o_Sequence  out  1  serial bit to detector
- o_Busy  out  1  high in every state except IDLE
- o_Done  out  1  one-cycle pulse, result valid
- o_DoneId  out  1  requester index of completed word
- o_MatchCount  out  CNT_W  match count of last completed word

## Operation
- States: IDLE, CLEAR, SHIFT, REPORT; all outputs registered or decoded from state only, except counting which samples i_X.
- IDLE: if i_Req ≠ 0, arbitrate, load winning word into shift register, record owner, go CLEAR. Otherwise stay.
- Arbitration: round-robin on `last` pointer. A single request wins outright. Both requesting: the requester ≠ `last` wins. `last` updates to the winner on capture.
- CLEAR (1 cycle): o_Grant[owner]=1, o_DetReset=1, match counter←0, bit index←0, then SHIFT.
- SHIFT (WORD_W cycles): o_Sequence = shreg[WORD_W-1]. At each edge: shreg shifts left (zero fill), index++, and if i_X=1 the counter increments. The counter saturates at 2^CNT_W−1. After index WORD_W−1 → REPORT.
- REPORT (1 cycle): o_Done=1, o_DoneId=owner, o_MatchCount=counter; → IDLE.
- o_MatchCount and o_DoneId hold until the next REPORT.
- o_Sequence=0 outside SHIFT; o_Grant, o_DetReset, o_Done=0 outside their states.
- Requester protocol: keep i_Req and word stable until o_Grant seen. Drop i_Req in the cycle after grant, else a new request is taken at next IDLE. Words are captured on the IDLE→CLEAR edge.
- Requests arriving while Busy wait; they are never lost or merged.
- Reset (any time, incl. mid-SHIFT): state→IDLE, all outputs 0, counter/shreg/index 0, `last`=1 (requester 0 wins first tie). The aborted word yields no o_Done; the requester must re-request.

## Timing
- Request high at IDLE edge t → CLEAR in cycle t+1 → SHIFT cycles t+2…t+WORD_W+1 → o_Done in cycle t+WORD_W+2.
- One word occupies WORD_W+2 cycles plus ≥1 IDLE cycle. Back-to-back throughput is one word per WORD_W+3 cycles.
- i_X is sampled on the same edge at which the detector advances on the presented bit, so a Mealy match on bit k counts for bit k.
- i_X outside SHIFT is ignored.
- Detector sees o_DetReset during CLEAR and is in its initial state on the first SHIFT cycle.

## Structure
- Shared package: state encoding enum (IDLE, CLEAR, SHIFT, REPORT), requester-index constants, default WORD_W/CNT_W.
- One natural sub-module: rr_arbiter2 (2-input round-robin, `last` pointer, one-hot grant). Serializer and counter stay inline.

## Test plan
- Single request: i_Req=01, i_Word0=8'hB4; bench drives i_X=1 on SHIFT cycles 3 and 6. Required: o_Grant=01 one cycle, o_Sequence=1,0,1,1,0,1,0,0, o_Done 10 cycles after request, o_MatchCount=2, o_DoneId=0.
- Tie and fairness: i_Req=11 held continuously. Required: grants alternate 0,1,0,1 from reset; o_DoneId tracks the grants.
- Saturation: CNT_W=2, i_X=1 every SHIFT cycle of an 8-bit word. Required: o_MatchCount=3.
- Detector clear: a second word immediately follows. Required: o_DetReset high exactly one cycle before each word's first bit, and counter restarts at 0.
- Reset mid-SHIFT: assert Reset at bit 4 for 1 ns. Required: all outputs 0 at once, no o_Done, and the next request is granted to requester 0 on a tie.
- Late request: i_Req=10 arrives during an active word. Required: granted only after that word's REPORT+IDLE, with its i_Word1 captured intact.
